// File: rtl/dvp_frame_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dvp_frame_ctrl_if : pixel stream from DVP capture plus FIFO write port      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface dvp_frame_ctrl_if;
  logic        in_valid;
  logic [31:0] in_pixel;
  logic        in_vs;
  logic [10:0] in_xaddr;
  logic [10:0] in_yaddr;
  logic        out_full;
  logic        out_wr_en;
  logic [31:0] out_wr_data;

  // master: capture stage and FIFO side; slave: the frame controller
  modport master (
    output in_valid, in_pixel, in_vs, in_xaddr, in_yaddr, out_full,
    input  out_wr_en, out_wr_data
  );

  modport slave (
    input  in_valid, in_pixel, in_vs, in_xaddr, in_yaddr, out_full,
    output out_wr_en, out_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/dvp_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dvp_frame_ctrl : frame-level capture sequencer (arm/skip/crop/bank ping-pong)|
// | Optional ROI cropping enabled by macro DVP_ROI_CROP_EN.   Rev 1.0           |
// +----------------------------------------------------------------------------+
module dvp_frame_ctrl #(
  parameter int SKIP_W = 4,
  parameter int PIX_W  = 22
) (
  input  logic                PCLK,
  input  logic                Rst_n,
  input  logic                cmd_start,
  input  logic                cmd_stop,
  input  logic                cmd_single,
  input  logic [SKIP_W-1:0]   skip_n,
  input  logic [10:0]         roi_x0,
  input  logic [10:0]         roi_x1,
  input  logic [10:0]         roi_y0,
  input  logic [10:0]         roi_y1,
  dvp_frame_ctrl_if.slave     bus,
  output logic                bank_sel,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_err,
  output logic [PIX_W-1:0]    frame_pixels,
  output logic [15:0]         frame_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    SKIP     = 2'd2,
    CAPTURE  = 2'd3
  } state_t;

  state_t              state;
  logic                vs_d;
  logic                sof;
  logic                eof;
  logic                single_lat;
  logic [SKIP_W-1:0]   skip_lat;
  logic [SKIP_W-1:0]   skip_cnt;
  logic [SKIP_W-1:0]   skip_nxt;
  logic                stop_pending;
  logic [PIX_W-1:0]    pix_cnt;
  logic                err_flag;
  logic                in_roi;
  logic                accept;
  logic                arm;

  assign sof      = bus.in_vs & ~vs_d;
  assign eof      = ~bus.in_vs & vs_d;
  assign busy     = (state != IDLE);
  assign arm      = (state == IDLE) & cmd_start & ~cmd_stop;
  assign accept   = (state == CAPTURE) & bus.in_valid & bus.in_vs & in_roi;
  assign skip_nxt = skip_cnt + SKIP_W'(1);

`ifdef DVP_ROI_CROP_EN
  logic [10:0] x0_lat;
  logic [10:0] x1_lat;
  logic [10:0] y0_lat;
  logic [10:0] y1_lat;

  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      x0_lat <= '0;
      x1_lat <= '0;
      y0_lat <= '0;
      y1_lat <= '0;
    end else if (arm) begin
      x0_lat <= roi_x0;
      x1_lat <= roi_x1;
      y0_lat <= roi_y0;
      y1_lat <= roi_y1;
    end
  end

  // inverted bounds naturally reject every pixel
  assign in_roi = (bus.in_xaddr >= x0_lat) && (bus.in_xaddr <= x1_lat) &&
                  (bus.in_yaddr >= y0_lat) && (bus.in_yaddr <= y1_lat);
`else
  logic unused_roi;
  assign unused_roi = ^{roi_x0, roi_x1, roi_y0, roi_y1, bus.in_xaddr, bus.in_yaddr};
  assign in_roi     = 1'b1;
`endif

  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state           <= IDLE;
      vs_d            <= 1'b0;
      single_lat      <= 1'b0;
      skip_lat        <= '0;
      skip_cnt        <= '0;
      stop_pending    <= 1'b0;
      pix_cnt         <= '0;
      err_flag        <= 1'b0;
      bus.out_wr_en   <= 1'b0;
      bus.out_wr_data <= '0;
      bank_sel        <= 1'b0;
      frame_done      <= 1'b0;
      frame_err       <= 1'b0;
      frame_pixels    <= '0;
      frame_cnt       <= '0;
    end else begin
      vs_d          <= bus.in_vs;
      frame_done    <= 1'b0;
      bus.out_wr_en <= 1'b0;

      if (accept) begin
        if (!bus.out_full) begin
          bus.out_wr_en   <= 1'b1;
          bus.out_wr_data <= bus.in_pixel;
          if (pix_cnt != '1)
            pix_cnt <= pix_cnt + PIX_W'(1);
        end else begin
          err_flag <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (arm) begin
            single_lat   <= cmd_single;
            skip_lat     <= skip_n;
            stop_pending <= 1'b0;
            state        <= WAIT_SOF;
          end
        end
        WAIT_SOF: begin
          if (cmd_stop) begin
            state <= IDLE;
          end else if (sof) begin
            pix_cnt  <= '0;
            err_flag <= 1'b0;
            state    <= CAPTURE;
          end
        end
        SKIP: begin
          if (cmd_stop) begin
            state <= IDLE;
          end else if (eof) begin
            skip_cnt <= skip_nxt;
            if (skip_nxt == skip_lat)
              state <= WAIT_SOF;
          end
        end
        CAPTURE: begin
          if (cmd_stop)
            stop_pending <= 1'b1;
          if (eof) begin
            frame_done   <= 1'b1;
            frame_err    <= err_flag;
            frame_pixels <= pix_cnt;
            frame_cnt    <= frame_cnt + 16'd1;
            bank_sel     <= ~bank_sel;
            // a stop arriving on the EOF cycle itself still ends the run
            if (single_lat || stop_pending || cmd_stop) begin
              state <= IDLE;
            end else if (skip_lat != '0) begin
              skip_cnt <= '0;
              state    <= SKIP;
            end else begin
              state <= WAIT_SOF;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dvp_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dvp_frame_ctrl : directed bench with data scoreboard for dvp_frame_ctrl  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_dvp_frame_ctrl;

  logic        PCLK;
  logic        Rst_n;
  logic        cmd_start;
  logic        cmd_stop;
  logic        cmd_single;
  logic [3:0]  skip_n;
  logic [10:0] roi_x0, roi_x1, roi_y0, roi_y1;
  logic        bank_sel;
  logic        busy;
  logic        frame_done;
  logic        frame_err;
  logic [21:0] frame_pixels;
  logic [15:0] frame_cnt;

  dvp_frame_ctrl_if bus ();

  dvp_frame_ctrl #(.SKIP_W(4), .PIX_W(22)) dut (
    .PCLK         (PCLK),
    .Rst_n        (Rst_n),
    .cmd_start    (cmd_start),
    .cmd_stop     (cmd_stop),
    .cmd_single   (cmd_single),
    .skip_n       (skip_n),
    .roi_x0       (roi_x0),
    .roi_x1       (roi_x1),
    .roi_y0       (roi_y0),
    .roi_y1       (roi_y1),
    .bus          (bus),
    .bank_sel     (bank_sel),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .frame_pixels (frame_pixels),
    .frame_cnt    (frame_cnt)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  int          wr_total   = 0;
  int          done_count = 0;
  logic [21:0] done_pix  [64];
  logic        done_err  [64];
  logic        done_bank [64];
  logic        done_busy [64];

  always @(negedge PCLK) begin
    if (Rst_n) begin
      if (bus.out_wr_en) begin
        wr_total++;
        if (exp_q.size() == 0)
          check_eq("wr_unexpected", exp_q.size(), 1);
        else
          check_eq("wr_data", bus.out_wr_data, exp_q.pop_front());
      end
      if (frame_done && done_count < 64) begin
        done_pix[done_count]  = frame_pixels;
        done_err[done_count]  = frame_err;
        done_bank[done_count] = bank_sel;
        done_busy[done_count] = busy;
        done_count++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int cur_x0, cur_x1, cur_y0, cur_y1;
  int tag    = 0;
  int word_k = 0;

  function automatic bit roi_ok(input int x, input int y);
    roi_ok = 1'b1;
`ifdef DVP_ROI_CROP_EN
    roi_ok = (x >= cur_x0) && (x <= cur_x1) && (y >= cur_y0) && (y <= cur_y1);
`endif
  endfunction

  task automatic arm(input bit single, input int skip, input int x0, input int x1,
                     input int y0, input int y1);
    @(negedge PCLK);
    cmd_start  = 1'b1;
    cmd_single = single;
    skip_n     = 4'(skip);
    roi_x0 = 11'(x0); roi_x1 = 11'(x1); roi_y0 = 11'(y0); roi_y1 = 11'(y1);
    cur_x0 = x0; cur_x1 = x1; cur_y0 = y0; cur_y1 = y1;
    @(negedge PCLK);
    cmd_start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge PCLK);
    cmd_stop = 1'b1;
    @(negedge PCLK);
    cmd_stop = 1'b0;
  endtask

  // capt: bench expects the controller to be capturing these lines
  task automatic send_lines(input int y0, input int y1, input int words, input bit capt,
                            input int full_start, input int full_len, input int stop_at);
    logic [31:0] d;
    for (int y = y0; y <= y1; y++) begin
      for (int x = 0; x < words; x++) begin
        @(negedge PCLK);
        d = {8'(tag), 2'b00, 11'(y), 11'(x)};
        bus.in_valid = 1'b1;
        bus.in_pixel = d;
        bus.in_xaddr = 11'(x);
        bus.in_yaddr = 11'(y);
        bus.out_full = (word_k >= full_start) && (word_k < full_start + full_len);
        cmd_stop     = (word_k == stop_at);
        if (capt && roi_ok(x, y) && !bus.out_full)
          exp_q.push_back(d);
        word_k++;
      end
      @(negedge PCLK);
      bus.in_valid = 1'b0;
      bus.out_full = 1'b0;
      cmd_stop     = 1'b0;
      @(negedge PCLK);
    end
  endtask

  task automatic send_frame(input int lines, input int words, input bit capt,
                            input int full_start, input int full_len, input int stop_at);
    @(negedge PCLK);
    bus.in_vs = 1'b1;
    word_k    = 0;
    tag++;
    send_lines(0, lines - 1, words, capt, full_start, full_len, stop_at);
    @(negedge PCLK);
    bus.in_vs = 1'b0;
    repeat (4) @(negedge PCLK);
  endtask

  int d0, w0, w1;

  initial begin
    Rst_n = 1'b0;
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_single = 1'b0; skip_n = '0;
    roi_x0 = '0; roi_x1 = '0; roi_y0 = '0; roi_y1 = '0;
    bus.in_valid = 1'b0; bus.in_pixel = '0; bus.in_vs = 1'b0;
    bus.in_xaddr = '0; bus.in_yaddr = '0; bus.out_full = 1'b0;
    repeat (3) @(negedge PCLK);

    check_eq("rst_busy",     busy,            0);
    check_eq("rst_wr_en",    bus.out_wr_en,   0);
    check_eq("rst_wr_data",  bus.out_wr_data, 0);
    check_eq("rst_bank",     bank_sel,        0);
    check_eq("rst_done",     frame_done,      0);
    check_eq("rst_err",      frame_err,       0);
    check_eq("rst_pixels",   frame_pixels,    0);
    check_eq("rst_cnt",      frame_cnt,       0);
    Rst_n = 1'b1;
    repeat (2) @(negedge PCLK);

    // continuous capture, no skip
    arm(0, 0, 0, 2047, 0, 2047);
    d0 = done_count; w0 = wr_total;
    repeat (3) send_frame(4, 8, 1, -1, 0, -1);
    check_eq("cont_done_n", done_count - d0, 3);
    check_eq("cont_writes", wr_total - w0, 96);
    for (int i = 0; i < 3; i++) begin
      check_eq("cont_pixels", done_pix[d0 + i], 32);
      check_eq("cont_err",    done_err[d0 + i], 0);
      check_eq("cont_bank",   done_bank[d0 + i], (i % 2 == 0) ? 1 : 0);
    end
    check_eq("cont_cnt", frame_cnt, 3);
    pulse_stop();
    check_eq("stop_waitsof_idle", busy, 0);

    // single mode armed mid-frame
    @(negedge PCLK);
    bus.in_vs = 1'b1; word_k = 0; tag++;
    w0 = wr_total;
    send_lines(0, 1, 8, 0, -1, 0, -1);
    arm(1, 0, 0, 2047, 0, 2047);
    send_lines(2, 3, 8, 0, -1, 0, -1);
    @(negedge PCLK);
    bus.in_vs = 1'b0;
    repeat (4) @(negedge PCLK);
    check_eq("single_partial_wr", wr_total - w0, 0);
    d0 = done_count; w0 = wr_total;
    send_frame(4, 8, 1, -1, 0, -1);
    check_eq("single_done_n",  done_count - d0, 1);
    check_eq("single_writes",  wr_total - w0, 32);
    check_eq("single_pixels",  done_pix[d0], 32);
    check_eq("single_busy_at_done", done_busy[d0], 0);

    // skip two frames between captures
    arm(0, 2, 0, 2047, 0, 2047);
    d0 = done_count;
    for (int f = 0; f < 7; f++) begin
      w0 = wr_total;
      send_frame(4, 8, (f % 3 == 0), -1, 0, -1);
      if (f % 3 != 0)
        check_eq("skip_no_wr", wr_total - w0, 0);
    end
    check_eq("skip_done_n", done_count - d0, 3);
    check_eq("skip_cnt", frame_cnt, 7);
    pulse_stop();
    check_eq("stop_skip_idle", busy, 0);
    w0 = wr_total;
    send_frame(4, 8, 0, -1, 0, -1);
    check_eq("stop_skip_no_wr", wr_total - w0, 0);

    // backpressure drops, then stop during capture
    arm(0, 0, 0, 2047, 0, 2047);
    d0 = done_count;
    send_frame(4, 8, 1, 10, 5, -1);
    send_frame(4, 8, 1, -1, 0, -1);
    send_frame(4, 8, 1, -1, 0, 5);
    check_eq("full_pixels",  done_pix[d0], 27);
    check_eq("full_err",     done_err[d0], 1);
    check_eq("after_pixels", done_pix[d0 + 1], 32);
    check_eq("after_err",    done_err[d0 + 1], 0);
    check_eq("stopcap_pixels", done_pix[d0 + 2], 32);
    check_eq("stopcap_busy_at_done", done_busy[d0 + 2], 0);
    check_eq("stopcap_cnt", frame_cnt, 10);
    w0 = wr_total;
    send_frame(4, 8, 0, -1, 0, -1);
    check_eq("stopcap_no_wr", wr_total - w0, 0);

    // start and stop together while idle
    @(negedge PCLK);
    cmd_start = 1'b1; cmd_stop = 1'b1;
    @(negedge PCLK);
    cmd_start = 1'b0; cmd_stop = 1'b0;
    check_eq("startstop_idle", busy, 0);
    d0 = done_count; w0 = wr_total;
    send_frame(4, 8, 0, -1, 0, -1);
    check_eq("startstop_no_wr",   wr_total - w0, 0);
    check_eq("startstop_no_done", done_count - d0, 0);

    // region of interest
    arm(1, 0, 2, 5, 1, 2);
    d0 = done_count; w0 = wr_total;
    send_frame(4, 8, 1, -1, 0, -1);
`ifdef DVP_ROI_CROP_EN
    w1 = 8;
`else
    w1 = 32;
`endif
    check_eq("roi_writes", wr_total - w0, w1);
    check_eq("roi_pixels", done_pix[d0], w1);
    arm(1, 0, 6, 2, 0, 3);
    d0 = done_count; w0 = wr_total;
    send_frame(4, 8, 1, -1, 0, -1);
`ifdef DVP_ROI_CROP_EN
    w1 = 0;
`else
    w1 = 32;
`endif
    check_eq("roi_inv_done_n", done_count - d0, 1);
    check_eq("roi_inv_pixels", done_pix[d0], w1);
    check_eq("roi_inv_writes", wr_total - w0, w1);
    check_eq("final_cnt", frame_cnt, 12);
    check_eq("sb_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
